prfc_table_loader: RTL and testbench

Streaming writer that fills the nine pRFC chunk-table BRAMs: phase0 0..5, phase1 0..1 and final. These are the tables the lookup controller later reads.
- Accepts a valid/ready word stream of header-plus-payload records and converts each payload word into a BRAM write with a sequential address.
- Reports session completion, per-table load status and protocol errors.
- Sits between the host/config interface and the BRAM write ports; the lookup path stays idle while load_busy is high.

---
 rtl/prfc_table_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_prfc_table_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prfc_table_loader.sv
// Streaming loader for the nine pRFC chunk-table BRAMs: header+payload records in, sequential BRAM writes out.
// Optional build macro PRFC_LOADER_CHECKSUM_EN adds an XOR trailer word per table (state CHK).
module prfc_table_loader #(
  parameter int unsigned DATA_WIDTH           = 32,
  parameter logic [31:0] PHASE0_CHUNK_NUM_0   = 32'd100,
  parameter logic [31:0] PHASE0_CHUNK_NUM_1   = 32'd100,
  parameter logic [31:0] PHASE0_CHUNK_NUM_2   = 32'd100,
  parameter logic [31:0] PHASE0_CHUNK_NUM_3   = 32'd150,
  parameter logic [31:0] PHASE0_CHUNK_NUM_4   = 32'd200,
  parameter logic [31:0] PHASE0_CHUNK_NUM_5   = 32'd250,
  parameter logic [31:0] PHASE1_CHUNK_NUM_0   = 32'd250,
  parameter logic [31:0] PHASE1_CHUNK_NUM_1   = 32'd250,
  parameter logic [31:0] FINALPHASE_CHUNK_NUM = 32'd250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_load,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [8:0]            bram_we,
  output logic [31:0]           bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [2:0]            err_code,
  output logic [8:0]            tables_loaded,
  output logic [2:0]            state_dbg
);

  // Stream handshake: a word transfers on a rising clk edge where s_valid && s_ready;
  // s_ready depends only on the current state and never drops inside HDR/DATA/CHK/ERR.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
`ifdef PRFC_LOADER_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [2:0] ERR_BAD_ID   = 3'd1;
  localparam logic [2:0] ERR_BAD_LEN  = 3'd2;
  localparam logic [2:0] ERR_LAST     = 3'd3;
`ifdef PRFC_LOADER_CHECKSUM_EN
  localparam logic [2:0] ERR_CHECKSUM = 3'd4;
`endif

  state_t state;
  state_t next_state;

  logic [3:0]  cur_id;
  logic [31:0] addr_cnt;
  logic [31:0] last_addr;
`ifdef PRFC_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  logic        beat;
  logic [3:0]  hdr_id;
  logic [27:0] hdr_count;
  logic        start_accept;
  logic        hdr_accept;
  logic        wr_beat;
  logic        mark_loaded;
  logic        raise_err;
  logic [2:0]  err_val;

  function automatic logic [31:0] depth_of(input logic [3:0] id);
    case (id)
      4'd0:    depth_of = PHASE0_CHUNK_NUM_0;
      4'd1:    depth_of = PHASE0_CHUNK_NUM_1;
      4'd2:    depth_of = PHASE0_CHUNK_NUM_2;
      4'd3:    depth_of = PHASE0_CHUNK_NUM_3;
      4'd4:    depth_of = PHASE0_CHUNK_NUM_4;
      4'd5:    depth_of = PHASE0_CHUNK_NUM_5;
      4'd6:    depth_of = PHASE1_CHUNK_NUM_0;
      4'd7:    depth_of = PHASE1_CHUNK_NUM_1;
      4'd8:    depth_of = FINALPHASE_CHUNK_NUM;
      default: depth_of = 32'd0;
    endcase
  endfunction

  function automatic logic [8:0] id_onehot(input logic [3:0] id);
    id_onehot = 9'd1 << id;
  endfunction

  assign s_ready   = (state == S_HDR) || (state == S_DATA) ||
`ifdef PRFC_LOADER_CHECKSUM_EN
                     (state == S_CHK) ||
`endif
                     (state == S_ERR);
  assign beat      = s_valid && s_ready;
  assign hdr_id    = s_data[31:28];
  assign hdr_count = s_data[27:0];
  assign load_done = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    hdr_accept   = 1'b0;
    wr_beat      = 1'b0;
    mark_loaded  = 1'b0;
    raise_err    = 1'b0;
    err_val      = 3'd0;
    case (state)
      S_IDLE: begin
        if (start_load) begin
          start_accept = 1'b1;
          next_state   = S_HDR;
        end
      end
      S_HDR: begin
        if (beat) begin
          if (hdr_id > 4'd8) begin
            raise_err = 1'b1;
            err_val   = ERR_BAD_ID;
          end else if ((hdr_count == 28'd0) || ({4'h0, hdr_count} > depth_of(hdr_id))) begin
            raise_err = 1'b1;
            err_val   = ERR_BAD_LEN;
          end else if (s_last) begin
            raise_err = 1'b1;
            err_val   = ERR_LAST;
          end else begin
            hdr_accept = 1'b1;
            next_state = S_DATA;
          end
          // An error raised on the session's final word has nothing left to drain.
          if (raise_err) next_state = s_last ? S_IDLE : S_ERR;
        end
      end
      S_DATA: begin
        if (beat) begin
          wr_beat = 1'b1;
          if (addr_cnt == last_addr) begin
`ifdef PRFC_LOADER_CHECKSUM_EN
            if (s_last) begin
              raise_err  = 1'b1;
              err_val    = ERR_LAST;
              next_state = S_IDLE;
            end else begin
              next_state = S_CHK;
            end
`else
            mark_loaded = 1'b1;
            next_state  = s_last ? S_DONE : S_HDR;
`endif
          end else if (s_last) begin
            raise_err  = 1'b1;
            err_val    = ERR_LAST;
            next_state = S_IDLE;
          end
        end
      end
`ifdef PRFC_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (beat) begin
          if (s_data == csum) begin
            mark_loaded = 1'b1;
            next_state  = s_last ? S_DONE : S_HDR;
          end else begin
            raise_err  = 1'b1;
            err_val    = ERR_CHECKSUM;
            next_state = s_last ? S_IDLE : S_ERR;
          end
        end
      end
`endif
      S_DONE: next_state = S_IDLE;
      S_ERR: begin
        if (beat && s_last) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we       <= '0;
      bram_addr     <= '0;
      bram_wdata    <= '0;
      load_busy     <= 1'b0;
      load_error    <= 1'b0;
      err_code      <= '0;
      tables_loaded <= '0;
      cur_id        <= '0;
      addr_cnt      <= '0;
      last_addr     <= '0;
`ifdef PRFC_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bram_we   <= '0;
      load_busy <= (next_state != S_IDLE);
      if (start_accept) begin
        tables_loaded <= '0;
        load_error    <= 1'b0;
        err_code      <= '0;
      end
      if (hdr_accept) begin
        cur_id    <= hdr_id;
        addr_cnt  <= '0;
        last_addr <= {4'h0, hdr_count} - 32'd1;
`ifdef PRFC_LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end
      if (wr_beat) begin
        bram_we   <= id_onehot(cur_id);
        bram_addr <= addr_cnt;
        // Phase0 tables hold 16-bit entries; the upper half is written as zero.
        if (cur_id < 4'd6) bram_wdata <= {{(DATA_WIDTH-16){1'b0}}, s_data[15:0]};
        else               bram_wdata <= s_data;
        addr_cnt  <= addr_cnt + 32'd1;
`ifdef PRFC_LOADER_CHECKSUM_EN
        csum      <= csum ^ s_data;
`endif
      end
      if (mark_loaded) tables_loaded <= tables_loaded | id_onehot(cur_id);
      if (raise_err) begin
        load_error <= 1'b1;
        err_code   <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_prfc_table_loader.sv
// Directed self-checking bench for prfc_table_loader; BRAM writes are scoreboarded against an expected queue.
`timescale 1ns/1ps
module tb_prfc_table_loader;

  localparam int W = 73;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        start_load;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [8:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [2:0]  err_code;
  logic [8:0]  tables_loaded;
  logic [2:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [31:0]  pay[$];
  int           n_cmp;
  int           n_err;
  int           done_cnt;
  int           done_base;

  prfc_table_loader dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .err_code(err_code), .tables_loaded(tables_loaded), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every nonzero bram_we must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_done) done_cnt++;
      if (bram_we != 9'd0) begin
        if (exp_q.size() == 0) check_eq("unexpected_write", {bram_we, bram_addr, bram_wdata}, 80'd0);
        else check_eq("write", {bram_we, bram_addr, bram_wdata}, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic push_write(input int id, input int addr, input logic [31:0] w);
    logic [8:0]  we;
    logic [31:0] wd;
    we = 9'd1 << id;
    wd = (id < 6) ? {16'h0, w[15:0]} : w;
    exp_q.push_back({we, addr[31:0], wd});
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check_eq("ready_timeout", {79'd0, s_ready}, 80'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'h0;
  endtask

  task automatic start_session();
    @(posedge clk); #1;
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    done_base = done_cnt;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // header, payload from pay[], optional trailer; pushes the expected writes
  task automatic send_table(input int id, input bit last, input bit gap);
    int          cnt;
    logic [31:0] x;
    cnt = pay.size();
    x = 32'h0;
    send_word({id[3:0], cnt[27:0]}, 1'b0, gap);
    for (int i = 0; i < cnt; i++) begin
      push_write(id, i, pay[i]);
      x = x ^ pay[i];
`ifdef PRFC_LOADER_CHECKSUM_EN
      send_word(pay[i], 1'b0, gap);
`else
      send_word(pay[i], last && (i == cnt - 1), gap);
`endif
    end
`ifdef PRFC_LOADER_CHECKSUM_EN
    send_word(x, last, gap);
`endif
    pay.delete();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0; done_base = 0;
    rst_n = 1'b0; start_load = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;
    #23;
    check_eq("rst_we", {71'd0, bram_we}, 80'd0);
    check_eq("rst_busy_err", {75'd0, s_ready, load_busy, load_done, load_error, err_code[0]}, 80'd0);
    rst_n = 1'b1;
    wait_cycles(2);
    check_eq("idle_state", {77'd0, state_dbg}, {77'd0, ST_IDLE});
    check_eq("idle_ready", {79'd0, s_ready}, 80'd0);
    check_eq("idle_loaded", {71'd0, tables_loaded}, 80'd0);

    // single phase0 table, 16-bit truncation
    start_session();
    check_eq("start_busy", {79'd0, load_busy}, 80'd1);
    pay = '{32'h11111234, 32'h22225678, 32'h3333ABCD};
    send_table(0, 1'b1, 1'b0);
    wait_cycles(3);
    check_eq("t1_done_pulses", done_cnt - done_base, 80'd1);
    check_eq("t1_loaded", {71'd0, tables_loaded}, 80'h001);
    check_eq("t1_busy_err", {78'd0, load_busy, load_error}, 80'd0);

    // two records with s_valid gaps
    start_session();
    check_eq("t2_cleared", {71'd0, tables_loaded}, 80'd0);
    pay = '{32'h0000000A, 32'h0000000B};
    send_table(6, 1'b0, 1'b1);
    pay = '{32'h0000000C};
    send_table(8, 1'b1, 1'b1);
    wait_cycles(3);
    check_eq("t2_done_pulses", done_cnt - done_base, 80'd1);
    check_eq("t2_loaded", {71'd0, tables_loaded}, 80'h140);

    // full-depth phase0 table (count == depth 100)
    start_session();
    for (int i = 0; i < 100; i++) pay.push_back(32'hA5A50000 + i * 32'h00010003);
    send_table(1, 1'b1, 1'b0);
    wait_cycles(3);
    check_eq("depth_loaded", {71'd0, tables_loaded}, 80'h002);
    check_eq("depth_queue_empty", exp_q.size(), 80'd0);

    // bad table id, drained until s_last
    start_session();
    send_word(32'h90000001, 1'b0, 1'b0);
    check_eq("badid_code", {77'd0, err_code}, 80'd1);
    check_eq("badid_flags", {77'd0, load_error, load_busy, s_ready}, 80'h7);
    check_eq("badid_state", {77'd0, state_dbg}, {77'd0, ST_ERR});
    send_word(32'h0000DEAD, 1'b0, 1'b0);
    send_word(32'h0000BEEF, 1'b1, 1'b0);
    wait_cycles(2);
    check_eq("badid_end", {76'd0, load_busy, load_error, err_code[1:0]}, 80'h5);
    check_eq("badid_idle", {77'd0, state_dbg}, {77'd0, ST_IDLE});
    start_session();
    check_eq("restart_clear", {76'd0, load_error, err_code}, 80'd0);

    // length 101 > depth 100
    send_word(32'h00000065, 1'b0, 1'b0);
    check_eq("len101_code", {77'd0, err_code}, 80'd2);
    send_word(32'h12345678, 1'b1, 1'b0);
    wait_cycles(1);
    check_eq("len101_busy", {79'd0, load_busy}, 80'd0);

    // zero length on the final word: straight back to IDLE
    start_session();
    send_word(32'h30000000, 1'b1, 1'b0);
    wait_cycles(1);
    check_eq("len0_code", {77'd0, err_code}, 80'd2);
    check_eq("len0_idle", {76'd0, load_busy, state_dbg}, {76'd0, 1'b0, ST_IDLE});

    // s_last on a header
    start_session();
    send_word(32'h00000001, 1'b1, 1'b0);
    wait_cycles(1);
    check_eq("hdrlast_code", {76'd0, load_error, err_code}, 80'hB);

    // s_last on 2nd of 4 payload words
    start_session();
    send_word(32'h20000004, 1'b0, 1'b0);
    push_write(2, 0, 32'hCAFE0001);
    send_word(32'hCAFE0001, 1'b0, 1'b0);
    push_write(2, 1, 32'hCAFE0002);
    send_word(32'hCAFE0002, 1'b1, 1'b0);
    wait_cycles(3);
    check_eq("early_last_code", {76'd0, load_error, err_code}, 80'hB);
    check_eq("early_last_loaded", {71'd0, tables_loaded}, 80'd0);
    check_eq("early_last_busy", {79'd0, load_busy}, 80'd0);
    check_eq("early_last_done", done_cnt - done_base, 80'd0);

`ifdef PRFC_LOADER_CHECKSUM_EN
    // trailer match / mismatch
    start_session();
    send_word(32'h10000002, 1'b0, 1'b0);
    push_write(1, 0, 32'h5);
    send_word(32'h5, 1'b0, 1'b0);
    push_write(1, 1, 32'h3);
    send_word(32'h3, 1'b0, 1'b0);
    send_word(32'h6, 1'b1, 1'b0);
    wait_cycles(2);
    check_eq("csum_ok_loaded", {71'd0, tables_loaded}, 80'h002);
    start_session();
    send_word(32'h10000002, 1'b0, 1'b0);
    push_write(1, 0, 32'h5);
    send_word(32'h5, 1'b0, 1'b0);
    push_write(1, 1, 32'h3);
    send_word(32'h3, 1'b0, 1'b0);
    send_word(32'h7, 1'b0, 1'b0);
    check_eq("csum_bad_code", {77'd0, err_code}, 80'd4);
    send_word(32'h0, 1'b1, 1'b0);
    wait_cycles(2);
    check_eq("csum_bad_loaded", {71'd0, tables_loaded}, 80'd0);
`endif

    // asynchronous reset while a write is in flight
    start_session();
    send_word(32'h70000003, 1'b0, 1'b0);
    push_write(7, 0, 32'h01234567);
    send_word(32'h01234567, 1'b0, 1'b0);
    wait_cycles(1);
    s_valid = 1'b1;
    s_data  = 32'h89ABCDEF;
    @(posedge clk); #1;
    check_eq("pre_reset_we", {39'd0, bram_we, bram_addr}, {39'd0, 9'h080, 32'd1});
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_we", {7'd0, bram_we, bram_addr, bram_wdata}, 80'd0);
    check_eq("async_rst_flags", {72'd0, s_ready, load_busy, load_done, load_error, err_code, 1'b0}, 80'd0);
    check_eq("async_rst_state", {68'd0, tables_loaded, state_dbg}, {77'd0, ST_IDLE});
    s_valid = 1'b0;
    s_data  = 32'h0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    check_eq("post_rst_we", {71'd0, bram_we}, 80'd0);

    // recovery after reset
    start_session();
    pay = '{32'hFEED4444};
    send_table(4, 1'b1, 1'b0);
    wait_cycles(3);
    check_eq("recover_loaded", {71'd0, tables_loaded}, 80'h010);
    check_eq("final_queue_empty", exp_q.size(), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
